// File: rtl/rom_dl_arbiter.sv
// Shares the ROM/sideways single-port RAM between Electron core accesses and the HPS ioctl download stream.
// Latency: core access acks 2 edges after its grant edge (3 from request); download byte writes 1 edge after it reaches the FIFO head.
// Backpressure: ioctl_wait is asserted with one slot of FIFO headroom; strobes hitting a full FIFO are dropped and flagged.
module rom_dl_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int MEM_BYTES    = 114688,
  parameter int DL_INDEX     = 0,
  parameter int DL_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_din,
  output logic [7:0]        core_dout,
  output logic              core_ack,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wren,
  input  logic [7:0]        mem_q,
  output logic              dl_busy,
  output logic              dl_overflow
);

  localparam int PTR_W = $clog2(DL_DEPTH);
  localparam int CNT_W = $clog2(DL_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [24:0]      MEM_LIM = 25'(MEM_BYTES);
  localparam logic [7:0]       DL_IDX  = 8'(DL_INDEX);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DL_DEPTH);
  localparam logic [CNT_W-1:0] WAIT_C  = CNT_W'(DL_DEPTH - 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CORE_A, CORE_D, DL_W} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dat;
  } dl_ent_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
  } core_acc_t;

  state_t           state, state_nxt;
  logic             dl_grant, core_grant;

  dl_ent_t          fifo_mem [DL_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full, fifo_empty;
  logic             dl_hit, push, pop;

  logic             pend_vld;
  core_acc_t        pend, live, req_sel;
  logic             req_any;
  logic [STV_W-1:0] starve;
  logic             cur_we;
  logic             dl_prev;

  // A byte is captured only when it targets this memory and lies inside the valid range;
  // the range check uses the full ioctl address before it is truncated to ADDR_W bits.
  assign dl_hit     = ioctl_wr & ioctl_download & (ioctl_index == DL_IDX) & (ioctl_addr < MEM_LIM);
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = dl_hit & ~fifo_full;
  assign pop        = dl_grant;

  // A pending request is older than a live one, so it is always serviced first.
  assign live    = {core_we, core_addr, core_din};
  assign req_any = pend_vld | core_req;
  assign req_sel = pend_vld ? pend : live;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and grant decode; core has priority unless the download has been starved.
  always_comb begin
    state_nxt  = state;
    dl_grant   = 1'b0;
    core_grant = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty && (!req_any || starve == STV_MAX)) begin
          dl_grant  = 1'b1;
          state_nxt = DL_W;
        end else if (req_any) begin
          core_grant = 1'b1;
          state_nxt  = CORE_A;
        end
      end
      CORE_A:  state_nxt = CORE_D;
      CORE_D:  state_nxt = IDLE;
      DL_W:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Download FIFO storage; pointers are reset separately so the payload needs no reset.
  always_ff @(posedge clk_sys) begin
    if (reset_n && push) fifo_mem[wr_ptr] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // One-deep pending slot for a core request that could not be granted immediately;
  // a further request arriving while it is occupied is a core protocol error and is dropped.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pend_vld <= 1'b0;
      pend     <= '0;
    end else if (pend_vld) begin
      if (core_grant) pend_vld <= 1'b0;
    end else if (core_req && !core_grant) begin
      pend_vld <= 1'b1;
      pend     <= live;
    end
  end

  // Starvation counter: counts core grants made while download bytes are waiting.
  always_ff @(posedge clk_sys) begin
    if (!reset_n)                      starve <= '0;
    else if (dl_grant || fifo_empty)   starve <= '0;
    else if (core_grant && starve != STV_MAX) starve <= starve + STV_W'(1);
  end

  // Memory port and core response; write enable is only ever high for the grant cycle.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_wren  <= 1'b0;
      core_dout <= '0;
      core_ack  <= 1'b0;
      cur_we    <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      core_ack <= 1'b0;
      if (dl_grant) begin
        mem_addr <= fifo_mem[rd_ptr].addr;
        mem_data <= fifo_mem[rd_ptr].dat;
        mem_wren <= 1'b1;
      end else if (core_grant) begin
        mem_addr <= req_sel.addr;
        mem_data <= req_sel.din;
        mem_wren <= req_sel.we;
        cur_we   <= req_sel.we;
      end
      if (state == CORE_D) begin
        core_ack <= 1'b1;
        if (!cur_we) core_dout <= mem_q;
      end
    end
  end

  // Registered download status; overflow is sticky until the next download starts.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ioctl_wait  <= 1'b0;
      dl_busy     <= 1'b0;
      dl_overflow <= 1'b0;
      dl_prev     <= 1'b0;
    end else begin
      ioctl_wait <= (count >= WAIT_C);
      dl_busy    <= ioctl_download | (count != '0);
      dl_prev    <= ioctl_download;
      if (dl_hit && fifo_full)              dl_overflow <= 1'b1;
      else if (ioctl_download && !dl_prev)  dl_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_dl_arbiter.sv
// Bench for rom_dl_arbiter: directed core/download traffic against a behavioural memory.
// Expected core responses and memory writes are queued at issue time and checked by a monitor.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_rom_dl_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        core_req, core_we;
  logic [16:0] core_addr;
  logic [7:0]  core_din, core_dout;
  logic        core_ack;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q;
  logic        dl_busy, dl_overflow;

  always #5 clk_sys = ~clk_sys;

  rom_dl_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
    .core_dout(core_dout), .core_ack(core_ack),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .dl_busy(dl_busy), .dl_overflow(dl_overflow)
  );

  typedef struct {
    logic       we;
    logic [7:0] q;
    int         due;
  } ack_exp_t;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  dat;
  } wr_exp_t;

  ack_exp_t ack_q[$];
  wr_exp_t  wr_q[$];
  ack_exp_t mon_a;
  wr_exp_t  mon_w;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ack_seen = 0;
  int   wr_seen = 0;
  int   wr_ack_mark = -1;
  int   exp_wr_total = 0;
  int   base;
  logic prev_wren = 1'b0;

  // Power-up contents of the memory; 0x04001 holds the known read value.
  function automatic logic [7:0] pat(input logic [16:0] a);
    if (a == 17'h04001) return 8'h5A;
    return a[7:0] ^ 8'h3C;
  endfunction

  // Single-port synchronous memory: q follows the address one clock later.
  logic [7:0] mem     [0:131071];
  bit         wr_flag [0:131071];
  always @(posedge clk_sys) begin
    if (mem_wren) begin
      mem[mem_addr]     <= mem_data;
      wr_flag[mem_addr] <= 1'b1;
    end
    mem_q <= wr_flag[mem_addr] ? mem[mem_addr] : pat(mem_addr);
  end

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack and every memory write must match the oldest expectation.
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1) begin
      if (core_ack) begin
        ack_seen++;
        if (ack_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
        else begin
          mon_a = ack_q.pop_front();
          if (!mon_a.we) check("core_dout", 32'(core_dout), 32'(mon_a.q));
          if (mon_a.due >= 0) check("ack_latency", 32'(cyc), 32'(mon_a.due));
        end
      end
      if (mem_wren) begin
        wr_seen++;
        wr_ack_mark = ack_seen;
        check("wren_single_cycle", 32'(prev_wren), 32'd0);
        if (wr_q.size() == 0) check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
          check("wr_data", 32'(mem_data), 32'(mon_w.dat));
        end
      end
    end
    prev_wren = mem_wren;
  end

  // Issue one core access; lat > 0 also checks the ack cycle. Returns on the ack.
  task automatic core_access(input logic we, input logic [16:0] a, input logic [7:0] d,
                             input logic [7:0] q, input int lat);
    ack_exp_t e;
    wr_exp_t  w;
    e.we  = we;
    e.q   = q;
    e.due = (lat > 0) ? cyc + lat : -1;
    ack_q.push_back(e);
    if (we) begin
      w.addr = a;
      w.dat  = d;
      wr_q.push_back(w);
      exp_wr_total++;
    end
    core_req  = 1'b1;
    core_we   = we;
    core_addr = a;
    core_din  = d;
    @(negedge clk_sys);
    core_req = 1'b0;
    for (int i = 0; i < 40 && !core_ack; i++) @(negedge clk_sys);
    if (!core_ack) check("core_ack_timeout", 32'd0, 32'd1);
  endtask

  // One download strobe; expect_wr says whether it should reach the memory.
  task automatic dl_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                         input bit expect_wr);
    wr_exp_t w;
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    if (expect_wr) begin
      w.addr = a[16:0];
      w.dat  = d;
      wr_q.push_back(w);
      exp_wr_total++;
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic core_read_burst(input logic [16:0] base_a, input int n);
    logic [16:0] a;
    for (int i = 0; i < n; i++) begin
      a = base_a + 17'(i);
      core_access(1'b0, a, 8'h00, pat(a), 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held while both requesters strobe.
    reset_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 17'h00100; core_din = 8'h00;
    ioctl_download = 1'b1; ioctl_index = 8'd0; ioctl_wr = 1'b1;
    ioctl_addr = 25'd0; ioctl_dout = 8'hEE;
    repeat (4) @(negedge clk_sys);
    check("rst_mem_addr",    32'(mem_addr),    32'd0);
    check("rst_mem_data",    32'(mem_data),    32'd0);
    check("rst_mem_wren",    32'(mem_wren),    32'd0);
    check("rst_core_ack",    32'(core_ack),    32'd0);
    check("rst_core_dout",   32'(core_dout),   32'd0);
    check("rst_ioctl_wait",  32'(ioctl_wait),  32'd0);
    check("rst_dl_busy",     32'(dl_busy),     32'd0);
    check("rst_dl_overflow", 32'(dl_overflow), 32'd0);
    core_req = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;

    // First read after reset, then write and read back.
    core_access(1'b0, 17'h04001, 8'h00, 8'h5A, 3);
    check("read_mem_addr", 32'(mem_addr), 32'h04001);
    core_access(1'b1, 17'h10020, 8'h77, 8'h00, 3);
    check("write_keeps_dout", 32'(core_dout), 32'h5A);
    core_access(1'b0, 17'h10020, 8'h00, 8'h77, 3);
    core_access(1'b0, 17'h10021, 8'h00, 8'h1D, 3);

    // Uncontended download, one byte every fourth clock.
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    dl_byte(8'd0, 25'd0, 8'h11, 1'b1);
    repeat (3) @(negedge clk_sys);
    dl_byte(8'd0, 25'd1, 8'h22, 1'b1);
    repeat (3) @(negedge clk_sys);
    dl_byte(8'd0, 25'd2, 8'h33, 1'b1);
    check("dl_busy_active", 32'(dl_busy), 32'd1);
    repeat (4) @(negedge clk_sys);
    check("dl_write_count", 32'(wr_seen), 32'(exp_wr_total));
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("dl_busy_idle", 32'(dl_busy), 32'd0);

    // Filtering: wrong index and first out-of-range address; last in-range byte kept.
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    dl_byte(8'd1, 25'h300, 8'h99, 1'b0);
    dl_byte(8'd0, 25'd114688, 8'h98, 1'b0);
    dl_byte(8'd0, 25'd114687, 8'h97, 1'b1);
    repeat (4) @(negedge clk_sys);
    check("filter_write_count", 32'(wr_seen), 32'(exp_wr_total));

    // Backpressure and overflow under continuous core traffic.
    fork
      core_read_burst(17'h11000, 40);
      begin
        repeat (6) @(negedge clk_sys);
        dl_byte(8'd0, 25'h200, 8'hB0, 1'b1);
        dl_byte(8'd0, 25'h201, 8'hB1, 1'b1);
        dl_byte(8'd0, 25'h202, 8'hB2, 1'b1);
        check("wait_at_count2", 32'(ioctl_wait), 32'd0);
        dl_byte(8'd0, 25'h203, 8'hB3, 1'b1);
        check("wait_at_count3", 32'(ioctl_wait), 32'd1);
        check("ovf_before_drop", 32'(dl_overflow), 32'd0);
        dl_byte(8'd0, 25'h204, 8'hB4, 1'b0);
        check("ovf_on_drop", 32'(dl_overflow), 32'd1);
      end
    join
    repeat (10) @(negedge clk_sys);
    check("bp_write_count", 32'(wr_seen), 32'(exp_wr_total));
    check("ovf_sticky", 32'(dl_overflow), 32'd1);
    check("wait_drained", 32'(ioctl_wait), 32'd0);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("ovf_sticky_dl_off", 32'(dl_overflow), 32'd1);
    check("busy_after_drain", 32'(dl_busy), 32'd0);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("ovf_clear_on_start", 32'(dl_overflow), 32'd0);

    // Starvation: a byte pushed together with a core request waits 8 more core grants.
    base = ack_seen;
    fork
      core_read_burst(17'h12000, 12);
      dl_byte(8'd0, 25'h100, 8'hC3, 1'b1);
    join
    repeat (4) @(negedge clk_sys);
    check("starve_grants", 32'(wr_ack_mark - base), 32'd9);
    check("collision_acks", 32'(ack_seen - base), 32'd12);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);

    check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
